decode_opnds_seq: RTL



---
 rtl/decode_opnds_seq_pkg.sv | 25 ++
 rtl/decode_opnds_seq_agu.sv | 28 ++
 rtl/decode_opnds_seq.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_opnds_seq_pkg.sv
// rtl/decode_opnds_seq_pkg.sv - shared encodings for the operand resolver
//
// Purpose: operand-kind and FSM state encodings used by decode_opnds_seq and its bench.
// Ports: none (package).
package decode_opnds_seq_pkg;

  typedef enum logic [1:0] {
    OPND_KIND_NONE = 2'd0,
    OPND_KIND_REG  = 2'd1,
    OPND_KIND_IMM  = 2'd2,
    OPND_KIND_MEM  = 2'd3
  } opnd_kind_e;

  typedef enum logic [2:0] {
    DOS_ST_IDLE  = 3'd0,
    DOS_ST_SEL   = 3'd1,
    DOS_ST_AGU   = 3'd2,
    DOS_ST_MATCH = 3'd3,
    DOS_ST_DONE  = 3'd4
  } dos_state_e;

  localparam int REG_COUNT = 8;
  localparam int SEL_W     = 3;

endpackage

// File: rtl/decode_opnds_seq_agu.sv
// rtl/decode_opnds_seq_agu.sv - effective address generator (base + index<<scale + disp)
//
// Purpose: combinational x86-style address generation, wrapping modulo 2^WIDTH.
// Ports:
//   base, index, disp  in  WIDTH  address terms
//   has_base/has_index in  1      0 forces the corresponding term to zero
//   scale              in  2      index shift amount
//   addr               out WIDTH  effective address
module decode_opnds_seq_agu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] base,
  input  logic             has_base,
  input  logic [WIDTH-1:0] index,
  input  logic             has_index,
  input  logic [1:0]       scale,
  input  logic [WIDTH-1:0] disp,
  output logic [WIDTH-1:0] addr
);

  logic [WIDTH-1:0] base_term;
  logic [WIDTH-1:0] index_term;

  assign base_term  = has_base  ? base : '0;
  assign index_term = has_index ? (index << scale) : '0;
  assign addr       = base_term + index_term + disp;

endmodule

// File: rtl/decode_opnds_seq.sv
// rtl/decode_opnds_seq.sv - sequential operand resolver between decode and execute
//
// Purpose: captures one instruction's operand descriptors, register snapshot and memory
// hints, then resolves operands one at a time (REG/IMM/NONE directly, MEM via address
// generation and a one-hint-per-cycle read-hint scan) and presents all results at once.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             descriptor bundle handshake (accept only when idle)
//   opnd_* , regs, hint_*           captured descriptor bundle
//   out_valid / out_ready           result handshake
//   opnd_r, opnd_addr, opnd_miss    per-operand value, effective address, read-hint miss
//   hint_used                       per-hint: satisfied at least one operand
module decode_opnds_seq
  import decode_opnds_seq_pkg::*;
#(
  parameter int NUM_OPNDS = 3,
  parameter int NUM_HINTS = 2,
  parameter int WIDTH     = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2*NUM_OPNDS-1:0]         opnd_kind,
  input  logic [SEL_W*NUM_OPNDS-1:0]     opnd_regsel,
  input  logic [SEL_W*NUM_OPNDS-1:0]     opnd_base_sel,
  input  logic [NUM_OPNDS-1:0]           opnd_has_base,
  input  logic [SEL_W*NUM_OPNDS-1:0]     opnd_index_sel,
  input  logic [NUM_OPNDS-1:0]           opnd_has_index,
  input  logic [2*NUM_OPNDS-1:0]         opnd_scale,
  input  logic [WIDTH*NUM_OPNDS-1:0]     opnd_disp,
  input  logic [WIDTH*NUM_OPNDS-1:0]     opnd_imm,
  input  logic [REG_COUNT*WIDTH-1:0]     regs,
  input  logic [NUM_HINTS-1:0]           hint_is_write,
  input  logic [WIDTH*NUM_HINTS-1:0]     hint_address,
  input  logic [WIDTH*NUM_HINTS-1:0]     hint_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH*NUM_OPNDS-1:0]     opnd_r,
  output logic [WIDTH*NUM_OPNDS-1:0]     opnd_addr,
  output logic [NUM_OPNDS-1:0]           opnd_miss,
  output logic [NUM_HINTS-1:0]           hint_used
);

  localparam int IDX_W  = $clog2(NUM_OPNDS + 1);
  localparam int HIDX_W = (NUM_HINTS > 1) ? $clog2(NUM_HINTS) : 1;
  localparam logic [IDX_W-1:0]  END_IDX   = IDX_W'(NUM_OPNDS);
  localparam logic [HIDX_W-1:0] LAST_HINT = HIDX_W'(NUM_HINTS - 1);

  dos_state_e                       state_q, state_d;
  logic [IDX_W-1:0]                 opnd_idx_q, opnd_idx_d;
  logic [HIDX_W-1:0]                hint_idx_q, hint_idx_d;
  logic [2*NUM_OPNDS-1:0]           kind_q, kind_d;
  logic [SEL_W*NUM_OPNDS-1:0]       regsel_q, regsel_d;
  logic [SEL_W*NUM_OPNDS-1:0]       base_sel_q, base_sel_d;
  logic [NUM_OPNDS-1:0]             has_base_q, has_base_d;
  logic [SEL_W*NUM_OPNDS-1:0]       index_sel_q, index_sel_d;
  logic [NUM_OPNDS-1:0]             has_index_q, has_index_d;
  logic [2*NUM_OPNDS-1:0]           scale_q, scale_d;
  logic [WIDTH*NUM_OPNDS-1:0]       disp_q, disp_d;
  logic [WIDTH*NUM_OPNDS-1:0]       imm_q, imm_d;
  logic [REG_COUNT*WIDTH-1:0]       regs_q, regs_d;
  logic [NUM_HINTS-1:0]             hint_wr_q, hint_wr_d;
  logic [WIDTH*NUM_HINTS-1:0]       hint_addr_q, hint_addr_d;
  logic [WIDTH*NUM_HINTS-1:0]       hint_data_q, hint_data_d;
  logic [WIDTH*NUM_OPNDS-1:0]       res_q, res_d;
  logic [WIDTH*NUM_OPNDS-1:0]       addr_q, addr_d;
  logic [NUM_OPNDS-1:0]             miss_q, miss_d;
  logic [NUM_HINTS-1:0]             used_q, used_d;

  // The SEL pass for a MEM operand is skipped: the state entered for an operand is
  // chosen from its kind when the previous one finishes. Past the last operand SEL is
  // entered once more and spends the single cycle that leads into DONE.
  function automatic dos_state_e entry_state(input logic [2*NUM_OPNDS-1:0] kinds,
                                             input int idx);
    if (idx >= NUM_OPNDS) return DOS_ST_SEL;
    if (kinds[idx*2 +: 2] == OPND_KIND_MEM) return DOS_ST_AGU;
    return DOS_ST_SEL;
  endfunction

  // Clamp keeps every indexed part-select in range while the end marker is held.
  int               cur_i;
  int               hint_i;
  opnd_kind_e       cur_kind;
  logic [WIDTH-1:0] cur_reg, base_val, index_val, agu_addr, cur_addr;
  logic [WIDTH-1:0] h_addr, h_data;
  logic             h_hit;
  dos_state_e       adv_state;
  logic [IDX_W-1:0] adv_idx;

  assign cur_i     = (opnd_idx_q < END_IDX) ? int'(opnd_idx_q) : 0;
  assign hint_i    = int'(hint_idx_q);
  assign cur_kind  = opnd_kind_e'(kind_q[cur_i*2 +: 2]);
  assign cur_reg   = regs_q[int'(regsel_q[cur_i*SEL_W +: SEL_W])*WIDTH +: WIDTH];
  assign base_val  = regs_q[int'(base_sel_q[cur_i*SEL_W +: SEL_W])*WIDTH +: WIDTH];
  assign index_val = regs_q[int'(index_sel_q[cur_i*SEL_W +: SEL_W])*WIDTH +: WIDTH];
  assign cur_addr  = addr_q[cur_i*WIDTH +: WIDTH];
  assign h_addr    = hint_addr_q[hint_i*WIDTH +: WIDTH];
  assign h_data    = hint_data_q[hint_i*WIDTH +: WIDTH];
  assign h_hit     = !hint_wr_q[hint_i] && (h_addr == cur_addr);
  assign adv_idx   = opnd_idx_q + 1'b1;
  assign adv_state = entry_state(kind_q, cur_i + 1);

  decode_opnds_seq_agu #(.WIDTH(WIDTH)) u_agu (
    .base      (base_val),
    .has_base  (has_base_q[cur_i]),
    .index     (index_val),
    .has_index (has_index_q[cur_i]),
    .scale     (scale_q[cur_i*2 +: 2]),
    .disp      (disp_q[cur_i*WIDTH +: WIDTH]),
    .addr      (agu_addr)
  );

  always_comb begin
    state_d     = state_q;
    opnd_idx_d  = opnd_idx_q;
    hint_idx_d  = hint_idx_q;
    kind_d      = kind_q;
    regsel_d    = regsel_q;
    base_sel_d  = base_sel_q;
    has_base_d  = has_base_q;
    index_sel_d = index_sel_q;
    has_index_d = has_index_q;
    scale_d     = scale_q;
    disp_d      = disp_q;
    imm_d       = imm_q;
    regs_d      = regs_q;
    hint_wr_d   = hint_wr_q;
    hint_addr_d = hint_addr_q;
    hint_data_d = hint_data_q;
    res_d       = res_q;
    addr_d      = addr_q;
    miss_d      = miss_q;
    used_d      = used_q;

    unique case (state_q)
      DOS_ST_IDLE: begin
        if (in_valid) begin
          kind_d      = opnd_kind;
          regsel_d    = opnd_regsel;
          base_sel_d  = opnd_base_sel;
          has_base_d  = opnd_has_base;
          index_sel_d = opnd_index_sel;
          has_index_d = opnd_has_index;
          scale_d     = opnd_scale;
          disp_d      = opnd_disp;
          imm_d       = opnd_imm;
          regs_d      = regs;
          hint_wr_d   = hint_is_write;
          hint_addr_d = hint_address;
          hint_data_d = hint_data;
          res_d       = '0;
          addr_d      = '0;
          miss_d      = '0;
          used_d      = '0;
          opnd_idx_d  = '0;
          hint_idx_d  = '0;
          state_d     = entry_state(opnd_kind, 0);
        end
      end
      DOS_ST_SEL: begin
        if (opnd_idx_q == END_IDX) begin
          state_d = DOS_ST_DONE;
        end else begin
          opnd_idx_d = adv_idx;
          state_d    = adv_state;
          unique case (cur_kind)
            OPND_KIND_REG:  res_d[cur_i*WIDTH +: WIDTH] = cur_reg;
            OPND_KIND_IMM:  res_d[cur_i*WIDTH +: WIDTH] = imm_q[cur_i*WIDTH +: WIDTH];
            OPND_KIND_MEM: begin
              opnd_idx_d = opnd_idx_q;
              state_d    = DOS_ST_AGU;
            end
            default:        res_d[cur_i*WIDTH +: WIDTH] = '0;
          endcase
        end
      end
      DOS_ST_AGU: begin
        addr_d[cur_i*WIDTH +: WIDTH] = agu_addr;
        hint_idx_d = '0;
        state_d    = DOS_ST_MATCH;
      end
      DOS_ST_MATCH: begin
        if (h_hit) begin
          res_d[cur_i*WIDTH +: WIDTH] = h_data;
          used_d[hint_i] = 1'b1;
          opnd_idx_d     = adv_idx;
          state_d        = adv_state;
        end else if (hint_idx_q == LAST_HINT) begin
          res_d[cur_i*WIDTH +: WIDTH] = '0;
          miss_d[cur_i] = 1'b1;
          opnd_idx_d    = adv_idx;
          state_d       = adv_state;
        end else begin
          hint_idx_d = hint_idx_q + 1'b1;
        end
      end
      DOS_ST_DONE: begin
        if (out_ready) state_d = DOS_ST_IDLE;
      end
      default: state_d = DOS_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DOS_ST_IDLE;
      opnd_idx_q  <= '0;
      hint_idx_q  <= '0;
      kind_q      <= '0;
      regsel_q    <= '0;
      base_sel_q  <= '0;
      has_base_q  <= '0;
      index_sel_q <= '0;
      has_index_q <= '0;
      scale_q     <= '0;
      disp_q      <= '0;
      imm_q       <= '0;
      regs_q      <= '0;
      hint_wr_q   <= '0;
      hint_addr_q <= '0;
      hint_data_q <= '0;
      res_q       <= '0;
      addr_q      <= '0;
      miss_q      <= '0;
      used_q      <= '0;
    end else begin
      state_q     <= state_d;
      opnd_idx_q  <= opnd_idx_d;
      hint_idx_q  <= hint_idx_d;
      kind_q      <= kind_d;
      regsel_q    <= regsel_d;
      base_sel_q  <= base_sel_d;
      has_base_q  <= has_base_d;
      index_sel_q <= index_sel_d;
      has_index_q <= has_index_d;
      scale_q     <= scale_d;
      disp_q      <= disp_d;
      imm_q       <= imm_d;
      regs_q      <= regs_d;
      hint_wr_q   <= hint_wr_d;
      hint_addr_q <= hint_addr_d;
      hint_data_q <= hint_data_d;
      res_q       <= res_d;
      addr_q      <= addr_d;
      miss_q      <= miss_d;
      used_q      <= used_d;
    end
  end

  assign in_ready  = (state_q == DOS_ST_IDLE);
  assign out_valid = (state_q == DOS_ST_DONE);
  assign opnd_r    = res_q;
  assign opnd_addr = addr_q;
  assign opnd_miss = miss_q;
  assign hint_used = used_q;

endmodule
